// File: rtl/iob_cache_axil_bridge.sv
// iob_cache_axil_bridge: cache native memory port to AXI4-Lite master.
// Define IOB_CACHE_AXIL_ERR_EN to add the sticky err output.
module iob_cache_axil_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NBYTES = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [NBYTES-1:0] wstrb,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
`ifdef IOB_CACHE_AXIL_ERR_EN
    output logic              err,
`endif

    output logic [ADDR_W-1:0] m_axil_awaddr,
    output logic [2:0]        m_axil_awprot,
    output logic              m_axil_awvalid,
    input  logic              m_axil_awready,

    output logic [DATA_W-1:0] m_axil_wdata,
    output logic [NBYTES-1:0] m_axil_wstrb,
    output logic              m_axil_wvalid,
    input  logic              m_axil_wready,

    input  logic [1:0]        m_axil_bresp,
    input  logic              m_axil_bvalid,
    output logic              m_axil_bready,

    output logic [ADDR_W-1:0] m_axil_araddr,
    output logic [2:0]        m_axil_arprot,
    output logic              m_axil_arvalid,
    input  logic              m_axil_arready,

    input  logic [DATA_W-1:0] m_axil_rdata,
    input  logic [1:0]        m_axil_rresp,
    input  logic              m_axil_rvalid,
    output logic              m_axil_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NBYTES-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;

    logic aw_done;
    logic w_done;
    logic b_fire;
    logic r_fire;

    // A channel counts as done once its valid has dropped or is handshaking now
    assign aw_done = ~awvalid_q | m_axil_awready;
    assign w_done  = ~wvalid_q | m_axil_wready;
    assign b_fire  = bready_q & m_axil_bvalid;
    assign r_fire  = rready_q & m_axil_rvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;

        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    if (|wstrb) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
                    end
                end
            end
            WADDR: begin
                if (m_axil_awready) begin
                    awvalid_d = 1'b0;
                end
                if (m_axil_wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (b_fire) begin
                    bready_d = 1'b0;
                    state_d  = DONE;
                end
            end
            RADDR: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (r_fire) begin
                    rdata_d  = m_axil_rdata;
                    rready_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready          = (state_q == DONE);
    assign rdata          = rdata_q;

    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = 3'b010;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = 3'b010;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

`ifdef IOB_CACHE_AXIL_ERR_EN
    logic err_q, err_d;
    logic unused_resp;

    // Only SLVERR/DECERR (resp[1]) are treated as errors
    assign err_d = err_q
                 | (b_fire & m_axil_bresp[1])
                 | (r_fire & m_axil_rresp[1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err         = err_q;
    assign unused_resp = m_axil_bresp[0] ^ m_axil_rresp[0];
`else
    logic unused_resp;

    assign unused_resp = ^{m_axil_bresp, m_axil_rresp};
`endif

endmodule

// File: tb/tb_iob_cache_axil_bridge.sv
// Bench for iob_cache_axil_bridge: AXI4-Lite slave model, directed table,
// hand-written corner sequences and a randomized request stream.
module tb_iob_cache_axil_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready;
`ifdef IOB_CACHE_AXIL_ERR_EN
    logic        err;
`endif
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = '0;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;

    iob_cache_axil_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .valid          (valid),
        .addr           (addr),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .rdata          (rdata),
        .ready          (ready),
`ifdef IOB_CACHE_AXIL_ERR_EN
        .err            (err),
`endif
        .m_axil_awaddr  (m_awaddr),
        .m_axil_awprot  (m_awprot),
        .m_axil_awvalid (m_awvalid),
        .m_axil_awready (m_awready),
        .m_axil_wdata   (m_wdata),
        .m_axil_wstrb   (m_wstrb),
        .m_axil_wvalid  (m_wvalid),
        .m_axil_wready  (m_wready),
        .m_axil_bresp   (m_bresp),
        .m_axil_bvalid  (m_bvalid),
        .m_axil_bready  (m_bready),
        .m_axil_araddr  (m_araddr),
        .m_axil_arprot  (m_arprot),
        .m_axil_arvalid (m_arvalid),
        .m_axil_arready (m_arready),
        .m_axil_rdata   (m_rdata),
        .m_axil_rresp   (m_rresp),
        .m_axil_rvalid  (m_rvalid),
        .m_axil_rready  (m_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // slave configuration, written by the test
    int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] bresp_cfg = '0, rresp_cfg = '0;

    // slave state and logs, written only by the slave process
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;
    logic [31:0] smem [0:255];
    bit          mem_init = 0;
    bit          aw_busy = 0, w_busy = 0, ar_busy = 0;
    bit          aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic [31:0] r_word = '0;

    // reference model
    logic [31:0] ref_mem [0:255];
    bit          ref_err = 0;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Slave: decides its outputs at negedge and records the handshakes
    // that will occur at the following posedge.
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) smem[i] = '0;
            smem[129] = 32'h1234_5678;
            mem_init = 1;
        end
        if (reset) begin
            m_awready = 0; m_wready = 0; m_bvalid = 0;
            m_arready = 0; m_rvalid = 0;
            aw_busy = 0; w_busy = 0; ar_busy = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        end else begin
            m_bresp = bresp_cfg;
            if (b_pend) begin
                if (b_cnt > 0) begin m_bvalid = 0; b_cnt--; end
                else m_bvalid = 1;
            end else m_bvalid = 0;
            if (m_bvalid && m_bready) begin b_pend = 0; b_hs++; end

            if (m_awvalid && !aw_busy) begin aw_busy = 1; aw_cnt = aw_dly; end
            if (aw_busy) begin
                if (aw_cnt > 0) begin m_awready = 0; aw_cnt--; end
                else m_awready = 1;
            end else m_awready = 0;
            if (m_awvalid && m_awready) begin
                aw_busy = 0; aw_got = 1; aw_hs++; last_awaddr = m_awaddr;
            end

            if (m_wvalid && !w_busy) begin w_busy = 1; w_cnt = w_dly; end
            if (w_busy) begin
                if (w_cnt > 0) begin m_wready = 0; w_cnt--; end
                else m_wready = 1;
            end else m_wready = 0;
            if (m_wvalid && m_wready) begin
                w_busy = 0; w_got = 1; w_hs++;
                last_wdata = m_wdata; last_wstrb = m_wstrb;
            end

            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0;
                smem[last_awaddr[9:2]] = merge(smem[last_awaddr[9:2]],
                                               last_wdata, last_wstrb);
                b_pend = 1; b_cnt = b_dly;
            end

            m_rresp = rresp_cfg;
            m_rdata = r_word;
            if (r_pend) begin
                if (r_cnt > 0) begin m_rvalid = 0; r_cnt--; end
                else m_rvalid = 1;
            end else m_rvalid = 0;
            if (m_rvalid && m_rready) begin r_pend = 0; r_hs++; end

            if (m_arvalid && !ar_busy) begin ar_busy = 1; ar_cnt = ar_dly; end
            if (ar_busy) begin
                if (ar_cnt > 0) begin m_arready = 0; ar_cnt--; end
                else m_arready = 1;
            end else m_arready = 0;
            if (m_arvalid && m_arready) begin
                ar_busy = 0; ar_hs++; last_araddr = m_araddr;
                r_pend = 1; r_cnt = r_dly; r_word = smem[m_araddr[9:2]];
            end
        end
    end

    // Protocol monitor: held valids keep their payload, no AW/W with AR,
    // ready never lasts two cycles.
    int          mon_n = 0, mon_bad = 0;
    bit          p_ok = 0;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rdy;
    logic [31:0] p_awa, p_wd, p_ara;
    logic [3:0]  p_ws;

    always @(posedge clk) begin
        if (reset) p_ok = 0;
        else begin
            if (p_ok) begin
                if (p_awv && !p_awr) begin
                    mon_n++;
                    if (!m_awvalid || m_awaddr !== p_awa) mon_bad++;
                end
                if (p_wv && !p_wr) begin
                    mon_n++;
                    if (!m_wvalid || m_wdata !== p_wd || m_wstrb !== p_ws) mon_bad++;
                end
                if (p_arv && !p_arr) begin
                    mon_n++;
                    if (!m_arvalid || m_araddr !== p_ara) mon_bad++;
                end
                if (ready && p_rdy) mon_bad++;
            end
            if ((m_awvalid || m_wvalid) && m_arvalid) mon_bad++;
            p_awv = m_awvalid; p_awr = m_awready; p_awa = m_awaddr;
            p_wv = m_wvalid; p_wr = m_wready; p_wd = m_wdata; p_ws = m_wstrb;
            p_arv = m_arvalid; p_arr = m_arready; p_ara = m_araddr;
            p_rdy = ready;
            p_ok = 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rst(input string nm);
        chk({nm, " valids"}, 64'({m_awvalid, m_wvalid, m_bready,
                                  m_arvalid, m_rready, ready}), 64'(0));
        chk({nm, " addrs"}, {m_awaddr, m_araddr}, 64'(0));
        chk({nm, " wdata"}, 64'({m_wstrb, m_wdata}), 64'(0));
        chk({nm, " rdata"}, 64'(rdata), 64'(0));
        chk({nm, " prot"}, 64'({m_awprot, m_arprot}), 64'(6'b010010));
`ifdef IOB_CACHE_AXIL_ERR_EN
        chk({nm, " err"}, 64'(err), 64'(0));
`endif
    endtask

    // Called at posedge+1 with the bridge idle (or in DONE when chaining).
    task automatic do_req(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit hold,
                          output int lat, output logic [31:0] rd,
                          output bit ok);
        valid = 1; addr = a; wdata = d; wstrb = s;
        lat = 0; rd = '0; ok = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (ready) begin lat = c; rd = rdata; ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL req timeout: no ready for addr %0h", a);
        end
        if (!hold) begin
            valid = 0;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_req(input string nm, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input int exp_lat, input logic [31:0] exp_rd,
                           input bit hold);
        int aw0, w0, b0, ar0, r0, lat;
        logic [31:0] rd;
        bit ok;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
        do_req(a, d, s, hold, lat, rd, ok);
        if (ok) begin
            chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
            if (s != 0) begin
                chk({nm, " hs aw/w/b/ar"},
                    64'({8'(aw_hs - aw0), 8'(w_hs - w0), 8'(b_hs - b0),
                         8'(ar_hs - ar0)}), 64'(32'h01010100));
                chk({nm, " awaddr"}, 64'(last_awaddr), 64'(a));
                chk({nm, " wdata/wstrb"}, 64'({last_wstrb, last_wdata}),
                    64'({s, d}));
            end else begin
                chk({nm, " hs aw/w/ar/r"},
                    64'({8'(aw_hs - aw0), 8'(w_hs - w0), 8'(ar_hs - ar0),
                         8'(r_hs - r0)}), 64'(32'h00000101));
                chk({nm, " araddr"}, 64'(last_araddr), 64'(a));
                chk({nm, " rdata"}, 64'(rd), 64'(exp_rd));
            end
        end
        if (s != 0) ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], d, s);
    endtask

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          awd, wd, bd, ard, rdl;
        int          exp_lat;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rd32;
        logic [3:0]  rs;
        int          el, aw0, w0;
        bit          found, wr;
        bit          sk_aw [1:9];
        bit          sk_w [1:9];
        bit          sk_b [1:9];
        bit          sk_r [1:9];

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_mem[129] = 32'h1234_5678;

        tbl[0] = '{"w100", 32'h100, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 3, 32'h0};
        tbl[1] = '{"r100", 32'h100, 32'h0, 4'h0, 0, 0, 0, 0, 0, 3, 32'hDEAD_BEEF};
        tbl[2] = '{"w100p", 32'h100, 32'h1122_3344, 4'h5, 1, 0, 0, 0, 0, 4, 32'h0};
        tbl[3] = '{"r100p", 32'h100, 32'h0, 4'h0, 0, 0, 0, 0, 1, 4, 32'hDE22_BE44};
        tbl[4] = '{"r204", 32'h204, 32'h0, 4'h0, 0, 0, 0, 0, 1, 4, 32'h1234_5678};
        tbl[5] = '{"w204", 32'h204, 32'hCAFE_F00D, 4'h8, 2, 0, 1, 0, 0, 6, 32'h0};
        tbl[6] = '{"r204b", 32'h204, 32'h0, 4'h0, 0, 0, 0, 2, 0, 5, 32'hCA34_5678};
        tbl[7] = '{"w3fc", 32'h3FC, 32'h0000_00A5, 4'h1, 0, 3, 2, 0, 0, 8, 32'h0};
        tbl[8] = '{"r3fc", 32'h3FC, 32'h0, 4'h0, 0, 0, 0, 1, 2, 6, 32'h0000_00A5};

        @(posedge clk); #1;
        chk_rst("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        chk_rst("post-reset idle");

        for (int i = 0; i < 9; i++) begin
            aw_dly = tbl[i].awd; w_dly = tbl[i].wd; b_dly = tbl[i].bd;
            ar_dly = tbl[i].ard; r_dly = tbl[i].rdl;
            run_req(tbl[i].nm, tbl[i].a, tbl[i].d, tbl[i].s,
                    tbl[i].exp_lat, tbl[i].exp_rd, 0);
        end

        // skewed write: W accepted at cycle 1, AW only at cycle 5
        aw_dly = 4; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        aw0 = aw_hs; w0 = w_hs;
        valid = 1; addr = 32'h80; wdata = 32'h5A5A_0F0F; wstrb = 4'hF;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            sk_aw[c] = m_awvalid; sk_w[c] = m_wvalid;
            sk_b[c] = m_bready; sk_r[c] = ready;
            if (ready) valid = 0;
        end
        valid = 0;
        ref_mem[32] = 32'h5A5A_0F0F;
        chk("skew awvalid c1-6", 64'({sk_aw[1], sk_aw[2], sk_aw[3], sk_aw[4],
                                      sk_aw[5], sk_aw[6]}), 64'(6'b111110));
        chk("skew wvalid c1-2", 64'({sk_w[1], sk_w[2], sk_w[5]}), 64'(3'b100));
        chk("skew bready c5-6", 64'({sk_b[5], sk_b[6]}), 64'(2'b01));
        chk("skew ready c6-8", 64'({sk_r[6], sk_r[7], sk_r[8]}), 64'(3'b010));
        chk("skew aw/w beats", 64'({8'(aw_hs - aw0), 8'(w_hs - w0)}),
            64'(16'h0101));

        // back-to-back write then read with valid held through DONE
        aw_dly = 0;
        run_req("b2b write", 32'h140, 32'h0BAD_F00D, 4'hF, 3, 32'h0, 1);
        run_req("b2b read", 32'h140, 32'h0, 4'h0, 4, 32'h0BAD_F00D, 0);

`ifdef IOB_CACHE_AXIL_ERR_EN
        bresp_cfg = 2'b10;
        run_req("slverr write", 32'h180, 32'h1111_2222, 4'h3, 3, 32'h0, 0);
        chk("err after slverr", 64'(err), 64'(1));
        bresp_cfg = 2'b00;
        run_req("okay read 1", 32'h180, 32'h0, 4'h0, 3, 32'h0000_2222, 0);
        chk("err sticky 1", 64'(err), 64'(1));
        run_req("okay read 2", 32'h100, 32'h0, 4'h0, 3, ref_mem[64], 0);
        chk("err sticky 2", 64'(err), 64'(1));
`endif

        // reset while waiting in RDATA with rready high
        r_dly = 6;
        valid = 1; addr = 32'h100; wstrb = 4'h0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (m_rready) begin found = 1; break; end
        end
        chk("rst-mid rready seen", 64'(found), 64'(1));
        #1;
        reset = 1; valid = 0;
        #1;
        chk_rst("rst-mid async");
        @(posedge clk); #1;
        chk_rst("rst-mid edge");
        @(posedge clk); #1;
        reset = 0; r_dly = 0;
        @(posedge clk); #1;
        run_req("post-rst read", 32'h100, 32'h0, 4'h0, 3, ref_mem[64], 0);

        ref_err = 0;
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            ra = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3);
            bresp_cfg = 2'($urandom_range(0, 3));
            rresp_cfg = 2'($urandom_range(0, 3));
            if (wr) begin
                rd32 = $urandom;
                rs = 4'($urandom_range(1, 15));
                el = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
                ref_err = ref_err | bresp_cfg[1];
                run_req("rand write", ra, rd32, rs, el, 32'h0, 0);
            end else begin
                el = 3 + ar_dly + r_dly;
                ref_err = ref_err | rresp_cfg[1];
                run_req("rand read", ra, 32'h0, 4'h0, el, ref_mem[ra[9:2]], 0);
            end
        end
`ifdef IOB_CACHE_AXIL_ERR_EN
        chk("err vs model", 64'(err), 64'(ref_err));
`endif

        chk("monitor active", 64'(mon_n > 0), 64'(1));
        chk("protocol monitor", 64'(mon_bad), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_cache_axil_bridge.md
# iob_cache_axil_bridge

Back-end bridge between the cache's native memory port (`mem_*`) and an AXI4-Lite master port toward the system interconnect. It sits directly downstream of the cache back-end. It accepts one native request at a time and converts it to either an AW/W/B write transaction or an AR/R read transaction, then returns a single-cycle `ready` pulse. It holds no data buffering beyond one request and one response, and it never reorders transactions.

## Interface
Parameters:
- `ADDR_W`, 32: native and AXI address width.
- `DATA_W`, 32: native and AXI data width; must be 32 or 64.
- `NBYTES`, `DATA_W/8`: strobe width. Derived; do not override.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `valid` in 1: native request valid. Held by the cache until `ready`.
- `addr` in `ADDR_W`: byte address of the request.
- `wdata` in `DATA_W`: write data.
- `wstrb` in `NBYTES`: write strobe. Nonzero means write; zero means read.
- `rdata` out `DATA_W`: read data. Valid only in the `ready` cycle.
- `ready` out 1: one-cycle completion pulse.
- `m_axil_awaddr` out `ADDR_W`, `m_axil_awprot` out 3 (tied 3'b010), `m_axil_awvalid` out 1, `m_axil_awready` in 1: write-address channel.
- `m_axil_wdata` out `DATA_W`, `m_axil_wstrb` out `NBYTES`, `m_axil_wvalid` out 1, `m_axil_wready` in 1: write-data channel.
- `m_axil_bresp` in 2, `m_axil_bvalid` in 1, `m_axil_bready` out 1: write-response channel.
- `m_axil_araddr` out `ADDR_W`, `m_axil_arprot` out 3 (tied 3'b010), `m_axil_arvalid` out 1, `m_axil_arready` in 1: read-address channel.
- `m_axil_rdata` in `DATA_W`, `m_axil_rresp` in 2, `m_axil_rvalid` in 1, `m_axil_rready` out 1: read-data channel.
- `err` out 1: sticky error flag. Present only with `IOB_CACHE_AXIL_ERR_EN`.

## Operation
State machine with states IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
- IDLE, `valid=1`:
  - Register `addr`, `wdata` and `wstrb` into the AXI output registers.
  - If `wstrb!=0`: set `awvalid=1` and `wvalid=1`, go to WADDR.
  - Otherwise: set `arvalid=1`, go to RADDR.
- WADDR:
  - `awvalid` clears on `awvalid&awready`; `wvalid` clears on `wvalid&wready`. The two clear independently and either may complete first or both may complete in the same cycle.
  - When both handshakes are complete (including any completing this cycle), go to WRESP and set `bready=1`.
- WRESP: on `bvalid&bready`, clear `bready` and go to DONE.
- RADDR: on `arvalid&arready`, clear `arvalid`, set `rready=1`, go to RDATA.
- RDATA: on `rvalid&rready`, capture `m_axil_rdata` into `rdata`, clear `rready`, go to DONE.
- DONE: `ready=1` for exactly one cycle, then go to IDLE.
- `valid` is not sampled outside IDLE. Request fields are frozen from acceptance to DONE.
- AXI outputs (`*valid`, `*addr`, `wdata`, `wstrb`) are registered and never change while a valid is asserted and unhandshaken.
- `bresp` and `rresp` values other than OKAY still complete the request normally. `rdata` is returned as received.

## Timing
- Reset values: all `*valid`/`*ready` outputs 0, `ready` 0, `rdata` 0, all addr/data/strb outputs 0, `err` 0, state IDLE.
- Reset asserted mid-transaction: return to IDLE immediately. The in-flight AXI transaction is abandoned; the interconnect is reset together with this block.
- Best-case latency with AXI readies tied high and a same-cycle response:
  - Cycle 0: IDLE samples `valid`.
  - Cycle 1: `awvalid`/`wvalid` or `arvalid` asserted.
  - Cycle 2: `bready` or `rready` asserted; the response handshake completes.
  - Cycle 3: `ready` pulses. Latency is 3 cycles from `valid` to `ready`.
- The cycle after DONE is IDLE, so back-to-back requests are accepted every 4 cycles at best.
- `rdata` is held until the next read capture.

## Configuration
- `IOB_CACHE_AXIL_ERR_EN` defined:
  - Adds the `err` port.
  - `err` is set on any `bvalid&bready` with `bresp[1]=1`, or any `rvalid&rready` with `rresp[1]=1`.
  - `err` is cleared only by `reset`.
- Not defined: no `err` port and no error logic. `bresp` and `rresp` are ignored.

## Test plan
- Write, readies high: `addr=0x100`, `wdata=0xDEADBEEF`, `wstrb=4'hF`, bvalid answered same cycle -> `awaddr=0x100`, `wdata=0xDEADBEEF`, `wstrb=4'hF` on cycle 1; `ready` on cycle 3; exactly one AW and one W handshake.
- Read: `addr=0x204`, `wstrb=0`, slave returns `rdata=0x12345678` two cycles after AR -> `araddr=0x204`; `ready=1` with `rdata=0x12345678` one cycle after the R handshake.
- Skewed write channels: `wready` high at cycle 1, `awready` delayed to cycle 5 -> `wvalid` drops at cycle 2, `awvalid` holds through cycle 5, `bready` rises at cycle 6; no duplicate W beat.
- Back-to-back write then read with `valid` held -> two separate AXI transactions in order, two `ready` pulses, no overlap between AW/W and AR.
- Error path with the macro defined: `bresp=2'b10` -> request completes, `err` goes 1 and stays 1 through later OKAY reads until `reset`.
- Reset asserted in RDATA with `rready=1` -> all outputs at reset values on the next edge; a new read afterwards completes normally.
